// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, sign fixed up at the end.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic             err,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

   typedef enum logic [5:0] {
      F_MFHI  = 6'b010000,
      F_MTHI  = 6'b010001,
      F_MFLO  = 6'b010010,
      F_MTLO  = 6'b010011,
      F_MULT  = 6'b011000,
      F_MULTU = 6'b011001,
      F_DIV   = 6'b011010,
      F_DIVU  = 6'b011011
   } funct_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   op_q;
   logic               div_q;
   logic               neg_q;
   logic               rneg_q;
   logic               dz_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               err_q;

   logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_md, is_div, is_signed, known;

   always_comb begin
      is_mfhi   = 1'b0;
      is_mflo   = 1'b0;
      is_mthi   = 1'b0;
      is_mtlo   = 1'b0;
      is_md     = 1'b0;
      is_div    = 1'b0;
      is_signed = 1'b0;
      case (funct)
         F_MFHI:  is_mfhi = 1'b1;
         F_MFLO:  is_mflo = 1'b1;
         F_MTHI:  is_mthi = 1'b1;
         F_MTLO:  is_mtlo = 1'b1;
         F_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
         F_MULTU: is_md = 1'b1;
         F_DIV:   begin is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
         F_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
         default: ;
      endcase
      known = is_mfhi | is_mflo | is_mthi | is_mtlo | is_md;
   end

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      a_neg = is_signed & srca[WIDTH-1];
      b_neg = is_signed & srcb[WIDTH-1];
      a_mag = a_neg ? -srca : srca;
      b_mag = b_neg ? -srcb : srcb;
   end

   // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
   logic [WIDTH:0]     mul_sum_d;
   logic [2*WIDTH-1:0] mul_next_d;
   // Divide: acc = {remainder, dividend/quotient}; shift left, subtract if it fits.
   logic [WIDTH:0]     div_rem_d;
   logic               div_ge_d;
   logic [WIDTH:0]     div_diff_d;
   logic [2*WIDTH-1:0] div_next_d;

   always_comb begin
      mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
      mul_next_d = {mul_sum_d, acc_q[WIDTH-1:1]};
      div_rem_d  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge_d   = (div_rem_d >= {1'b0, op_q});
      div_diff_d = div_rem_d - {1'b0, op_q};
      div_next_d = {(div_ge_d ? div_diff_d[WIDTH-1:0] : div_rem_d[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge_d};
   end

   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH-1:0]   quot_d, rem_d, fix_hi_d, fix_lo_d;

   always_comb begin
      prod_d = neg_q ? -acc_q : acc_q;
      quot_d = acc_q[WIDTH-1:0];
      rem_d  = acc_q[2*WIDTH-1:WIDTH];
      if (div_q) begin
         // Divide-by-zero leaves the dividend magnitude in the remainder, so re-signing restores srca.
         fix_lo_d = dz_q ? '1 : (neg_q ? -quot_d : quot_d);
         fix_hi_d = rneg_q ? -rem_d : rem_d;
      end else begin
         fix_lo_d = prod_d[WIDTH-1:0];
         fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         op_q    <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= valid & ~known;
         case (state_q)
            S_IDLE: begin
               if (valid) begin
                  if (is_mthi) hi_q <= srca;
                  if (is_mtlo) lo_q <= srca;
                  if (is_md) begin
                     state_q <= S_RUN;
                     cnt_q   <= CW'(WIDTH);
                     op_q    <= is_div ? b_mag : a_mag;
                     acc_q   <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                     div_q   <= is_div;
                     neg_q   <= a_neg ^ b_neg;
                     rneg_q  <= a_neg;
                     dz_q    <= is_div & (srcb == '0);
                  end
               end
            end
            S_RUN: begin
               acc_q <= div_q ? div_next_d : mul_next_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= S_FIX;
            end
            S_FIX: begin
               hi_q    <= fix_hi_d;
               lo_q    <= fix_lo_d;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy  = (state_q != S_IDLE);
      stall = valid & known & busy;
      if (valid && !busy && is_mfhi)
         result = hi_q;
      else if (valid && !busy && is_mflo)
         result = lo_q;
      else
         result = '0;
      hi   = hi_q;
      lo   = lo_q;
      done = done_q;
      err  = err_q;
   end

endmodule
